// File: rtl/data_memory_if.sv
// Bus between the ALU/control path and the data memory stage of the RV64I datapath.
// The memory is the slave; the datapath (or a testbench) is the master.
interface data_memory_if;
    logic [63:0] address;
    logic [63:0] write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [63:0] read_data;
    logic        ready;
    logic        misaligned;
    logic        out_of_range;
    logic        fault;

    modport slave (
        input  address, write_data, MemRead, MemWrite, funct3,
        output read_data, ready, misaligned, out_of_range, fault
    );

    modport master (
        output address, write_data, MemRead, MemWrite, funct3,
        input  read_data, ready, misaligned, out_of_range, fault
    );
endinterface

// File: rtl/data_memory.sv
// RV64I data memory: doubleword array with byte-lane stores, sign/zero-extended loads,
// self-clearing after reset, and misalignment / range flagging with a sticky fault.
module data_memory #(
    parameter int DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    data_memory_if.slave       bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [AW-1:0]  r_count;
    logic           r_fault;
    logic [63:0]    r_mem [DEPTH];

    logic           w_run;
    logic           w_active;
    logic [AW-1:0]  w_index;
    logic [2:0]     w_offset;
    logic [1:0]     w_size;
    logic           w_bad_align;
    logic           w_illegal;
    logic           w_misaligned;
    logic           w_out_of_range;
    logic           w_legal;
    logic [63:0]    w_word;
    logic [63:0]    w_shifted;
    logic [63:0]    w_ext;
    logic [7:0]     w_size_mask;
    logic [7:0]     w_lane_mask;
    logic [63:0]    w_wdata_sh;
    logic           w_init_we;
    logic           w_store_we;

    // A reset cycle is never treated as RUN, so flags and loads are quiet while rst_n is low.
    assign w_run          = (r_state == ST_RUN) && rst_n;
    assign w_active       = bus.MemRead || bus.MemWrite;
    assign w_index        = bus.address[AW+2:3];
    assign w_offset       = bus.address[2:0];
    assign w_size         = bus.funct3[1:0];
    assign w_illegal      = (bus.funct3 == 3'b111);
    assign w_misaligned   = w_run && w_active && (w_bad_align || w_illegal);
    assign w_out_of_range = w_run && w_active && (|bus.address[63:AW+3]);
    assign w_legal        = w_run && !w_misaligned && !w_out_of_range;
    assign w_word         = r_mem[w_index];
    assign w_init_we      = rst_n && (r_state == ST_INIT);
    assign w_store_we     = w_legal && bus.MemWrite;

    // Alignment check and lane mask derived from the access size.
    always_comb begin
        w_bad_align = 1'b0;
        w_size_mask = 8'h00;
        case (w_size)
            2'b00: begin w_bad_align = 1'b0;          w_size_mask = 8'h01; end
            2'b01: begin w_bad_align = w_offset[0];   w_size_mask = 8'h03; end
            2'b10: begin w_bad_align = |w_offset[1:0]; w_size_mask = 8'h0F; end
            2'b11: begin w_bad_align = |w_offset;     w_size_mask = 8'hFF; end
            default: begin w_bad_align = 1'b1;        w_size_mask = 8'h00; end
        endcase
    end

    assign w_lane_mask = 8'(w_size_mask << w_offset);
    assign w_wdata_sh  = bus.write_data << {w_offset, 3'b000};

    // Load path: bring the addressed bytes to bit 0, then extend per funct3[2].
    always_comb begin
        w_shifted = w_word >> {w_offset, 3'b000};
        w_ext     = 64'd0;
        case (w_size)
            2'b00:   w_ext = bus.funct3[2] ? {56'd0, w_shifted[7:0]}  : {{56{w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_ext = bus.funct3[2] ? {48'd0, w_shifted[15:0]} : {{48{w_shifted[15]}}, w_shifted[15:0]};
            2'b10:   w_ext = bus.funct3[2] ? {32'd0, w_shifted[31:0]} : {{32{w_shifted[31]}}, w_shifted[31:0]};
            2'b11:   w_ext = w_shifted;
            default: w_ext = 64'd0;
        endcase
    end

    assign bus.read_data    = (w_legal && bus.MemRead) ? w_ext : 64'd0;
    assign bus.misaligned   = w_misaligned;
    assign bus.out_of_range = w_out_of_range;
    assign bus.ready        = w_run;
    assign bus.fault        = r_fault && rst_n;

    // Next-state logic: INIT runs until the last word has been cleared.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: begin
                if (r_count == AW'(DEPTH - 1)) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_INIT;
                end
            end
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    // State, clear counter and sticky fault register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_count <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= (r_state == ST_INIT) ? r_count + AW'(1) : r_count;
            r_fault <= r_fault || (w_run && (w_misaligned || w_out_of_range));
        end
    end

    // Array write port: zero fill during INIT, byte-lane stores during RUN.
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[r_count] <= 64'd0;
        end else if (w_store_we) begin
            for (int b = 0; b < 8; b++) begin
                if (w_lane_mask[b]) begin
                    r_mem[w_index][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end
endmodule
